// File: rtl/deadtime_monitor_pkg.sv
// rtl/deadtime_monitor_pkg.sv - shared types, defaults and helpers for the dead-time monitor
package deadtime_monitor_pkg;

    localparam int DT_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_P_ON    = 3'd2,
        ST_N_ON    = 3'd3,
        ST_GAP_P   = 3'd4,
        ST_GAP_N   = 3'd5,
        ST_OVERLAP = 3'd6
    } dtm_state_t;

    // Pin level to logical "active": polarity bit 1 means the pin is active-low.
    function automatic logic dtm_norm(input logic sig, input logic pol);
        return sig ^ pol;
    endfunction

endpackage

// File: rtl/deadtime_monitor_gap_counter.sv
// rtl/deadtime_monitor_gap_counter.sv - saturating gap counter with load-1, increment and clear
module dtm_gap_counter #(
    parameter int DT_W = 10
) (
    input  logic            pe_gen_clk,
    input  logic            pe_gen_rstn,
    input  logic            clr_i,
    input  logic            load1_i,
    input  logic            inc_i,
    output logic [DT_W-1:0] cnt_o
);

    logic [DT_W-1:0] cnt_q;
    logic [DT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = {{(DT_W-1){1'b0}}, 1'b1};
        end else if (inc_i && (cnt_q != {DT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
        if (!pe_gen_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/deadtime_monitor.sv
// rtl/deadtime_monitor.sv - measures P/N dead-time gaps and flags short gaps and shoot-through
module deadtime_monitor
    import deadtime_monitor_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            pe_gen_clk,
    input  logic            pe_gen_rstn,
    input  logic            r_dtm_en,
    input  logic            r_ccp,
    input  logic            r_ccnp,
    input  logic [DT_W-1:0] r_dtg_min,
    input  logic            r_dtm_clr,
    input  logic            channelp,
    input  logic            channeln,
    output logic [DT_W-1:0] dtm_pn,
    output logic [DT_W-1:0] dtm_np,
    output logic            dtm_valid,
    output logic            dt_short_flag,
    output logic            st_flag,
    output logic            st_brk
);

    logic pa;
    logic na;
    assign pa = dtm_norm(channelp, r_ccp);
    assign na = dtm_norm(channeln, r_ccnp);

    dtm_state_t      state_q, state_d;
    logic            cnt_load1, cnt_inc, cnt_clr;
    logic [DT_W-1:0] cnt;
    logic            pn_upd, np_upd, meas_upd;
    logic [DT_W-1:0] meas_val;
    logic            short_set, st_set;

    logic [DT_W-1:0] dtm_pn_q, dtm_np_q;
    logic            dtm_valid_q, dt_short_q, st_flag_q, st_brk_q;

    always_comb begin
        state_d   = state_q;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        pn_upd    = 1'b0;
        np_upd    = 1'b0;
        meas_val  = '0;
        if (!r_dtm_en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_WAIT;
                ST_WAIT, ST_OVERLAP: begin
                    case ({pa, na})
                        2'b10:   state_d = ST_P_ON;
                        2'b01:   state_d = ST_N_ON;
                        2'b11:   state_d = ST_OVERLAP;
                        default: state_d = ST_WAIT;
                    endcase
                end
                ST_P_ON: begin
                    case ({pa, na})
                        2'b00: begin
                            state_d   = ST_GAP_P;
                            cnt_load1 = 1'b1;
                        end
                        2'b01: begin
                            state_d = ST_N_ON;
                            pn_upd  = 1'b1;
                        end
                        2'b11:   state_d = ST_OVERLAP;
                        default: state_d = ST_P_ON;
                    endcase
                end
                ST_N_ON: begin
                    case ({pa, na})
                        2'b00: begin
                            state_d   = ST_GAP_N;
                            cnt_load1 = 1'b1;
                        end
                        2'b10: begin
                            state_d = ST_P_ON;
                            np_upd  = 1'b1;
                        end
                        2'b11:   state_d = ST_OVERLAP;
                        default: state_d = ST_N_ON;
                    endcase
                end
                ST_GAP_P: begin
                    case ({pa, na})
                        2'b00:   cnt_inc = 1'b1;
                        2'b01: begin
                            state_d  = ST_N_ON;
                            pn_upd   = 1'b1;
                            meas_val = cnt;
                        end
                        2'b10:   state_d = ST_P_ON;
                        default: state_d = ST_OVERLAP;
                    endcase
                end
                ST_GAP_N: begin
                    case ({pa, na})
                        2'b00:   cnt_inc = 1'b1;
                        2'b10: begin
                            state_d  = ST_P_ON;
                            np_upd   = 1'b1;
                            meas_val = cnt;
                        end
                        2'b01:   state_d = ST_N_ON;
                        default: state_d = ST_OVERLAP;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outside an active gap the counter is held at zero, so disable discards it.
    assign cnt_clr = ~(cnt_load1 | cnt_inc);

    dtm_gap_counter #(.DT_W(DT_W)) u_gap_counter (
        .pe_gen_clk  (pe_gen_clk),
        .pe_gen_rstn (pe_gen_rstn),
        .clr_i       (cnt_clr),
        .load1_i     (cnt_load1),
        .inc_i       (cnt_inc),
        .cnt_o       (cnt)
    );

    assign meas_upd  = pn_upd | np_upd;
    assign short_set = meas_upd && (meas_val < r_dtg_min);
    assign st_set    = (state_d == ST_OVERLAP) && (state_q != ST_OVERLAP);

    always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
        if (!pe_gen_rstn) begin
            state_q     <= ST_IDLE;
            dtm_pn_q    <= '0;
            dtm_np_q    <= '0;
            dtm_valid_q <= 1'b0;
            dt_short_q  <= 1'b0;
            st_flag_q   <= 1'b0;
            st_brk_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dtm_valid_q <= meas_upd;
            st_brk_q    <= st_set;
            if (pn_upd) begin
                dtm_pn_q <= meas_val;
            end
            if (np_upd) begin
                dtm_np_q <= meas_val;
            end
            // A set in the same cycle as the clear pulse takes priority.
            dt_short_q <= short_set | (dt_short_q & ~r_dtm_clr);
            st_flag_q  <= st_set | (st_flag_q & ~r_dtm_clr);
        end
    end

    assign dtm_pn        = dtm_pn_q;
    assign dtm_np        = dtm_np_q;
    assign dtm_valid     = dtm_valid_q;
    assign dt_short_flag = dt_short_q;
    assign st_flag       = st_flag_q;
    assign st_brk        = st_brk_q;

endmodule

// File: tb/tb_deadtime_monitor.sv
// tb/tb_deadtime_monitor.sv - directed self-checking bench for deadtime_monitor
module tb_deadtime_monitor;

    localparam int DT_W = 10;

    logic            pe_gen_clk;
    logic            pe_gen_rstn;
    logic            r_dtm_en;
    logic            r_ccp;
    logic            r_ccnp;
    logic [DT_W-1:0] r_dtg_min;
    logic            r_dtm_clr;
    logic            channelp;
    logic            channeln;
    logic [DT_W-1:0] dtm_pn;
    logic [DT_W-1:0] dtm_np;
    logic            dtm_valid;
    logic            dt_short_flag;
    logic            st_flag;
    logic            st_brk;

    int errors = 0;
    int checks = 0;
    int vcnt = 0;
    int bcnt = 0;
    int vsnap;
    int bsnap;

    deadtime_monitor #(.DT_W(DT_W)) dut (
        .pe_gen_clk    (pe_gen_clk),
        .pe_gen_rstn   (pe_gen_rstn),
        .r_dtm_en      (r_dtm_en),
        .r_ccp         (r_ccp),
        .r_ccnp        (r_ccnp),
        .r_dtg_min     (r_dtg_min),
        .r_dtm_clr     (r_dtm_clr),
        .channelp      (channelp),
        .channeln      (channeln),
        .dtm_pn        (dtm_pn),
        .dtm_np        (dtm_np),
        .dtm_valid     (dtm_valid),
        .dt_short_flag (dt_short_flag),
        .st_flag       (st_flag),
        .st_brk        (st_brk)
    );

    initial pe_gen_clk = 1'b0;
    always #5 pe_gen_clk = ~pe_gen_clk;

    always @(negedge pe_gen_clk) begin
        if (dtm_valid) vcnt++;
        if (st_brk) bcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pe_gen_clk);
        #1;
    endtask

    task automatic drive(input logic p_act, input logic n_act);
        channelp = p_act ^ r_ccp;
        channeln = n_act ^ r_ccnp;
    endtask

    initial begin
        pe_gen_rstn = 1'b0;
        r_dtm_en    = 1'b0;
        r_ccp       = 1'b0;
        r_ccnp      = 1'b0;
        r_dtg_min   = 10'd8;
        r_dtm_clr   = 1'b0;
        drive(1'b0, 1'b0);
        #23;
        chk("rst_pn", dtm_pn, 0);
        chk("rst_np", dtm_np, 0);
        chk("rst_valid", dtm_valid, 0);
        chk("rst_short", dt_short_flag, 0);
        chk("rst_st", st_flag, 0);
        chk("rst_brk", st_brk, 0);
        pe_gen_rstn = 1'b1;

        // 1: nominal P->N gap of 8, N->P gap of 10
        r_dtm_en = 1'b1;
        tick(2);
        drive(1'b1, 1'b0);
        tick(20);
        drive(1'b0, 1'b0);
        tick(8);
        vsnap = vcnt;
        drive(1'b0, 1'b1);
        tick(1);
        chk("nom_pn", dtm_pn, 8);
        chk("nom_valid_hi", dtm_valid, 1);
        chk("nom_short", dt_short_flag, 0);
        tick(1);
        chk("nom_valid_lo", dtm_valid, 0);
        chk("nom_valid_cnt", vcnt - vsnap, 1);
        tick(10);
        drive(1'b0, 1'b0);
        tick(10);
        drive(1'b1, 1'b0);
        tick(1);
        chk("nom_np", dtm_np, 10);
        chk("nom_np_valid", dtm_valid, 1);
        chk("nom_np_short", dt_short_flag, 0);

        // 2: short gap, clear alone, clear colliding with a new short
        tick(5);
        drive(1'b0, 1'b0);
        tick(3);
        drive(1'b0, 1'b1);
        tick(1);
        chk("short_pn", dtm_pn, 3);
        chk("short_flag", dt_short_flag, 1);
        tick(2);
        r_dtm_clr = 1'b1;
        tick(1);
        r_dtm_clr = 1'b0;
        chk("short_clr", dt_short_flag, 0);
        drive(1'b0, 1'b0);
        tick(2);
        drive(1'b1, 1'b0);
        r_dtm_clr = 1'b1;
        tick(1);
        r_dtm_clr = 1'b0;
        chk("short_np", dtm_np, 2);
        chk("short_set_wins", dt_short_flag, 1);

        // 3: shoot-through from P_ON, then P drops into N_ON
        tick(3);
        vsnap = vcnt;
        bsnap = bcnt;
        drive(1'b1, 1'b1);
        tick(1);
        chk("st_brk_hi", st_brk, 1);
        tick(1);
        chk("st_brk_lo", st_brk, 0);
        chk("st_brk_cnt", bcnt - bsnap, 1);
        chk("st_flag", st_flag, 1);
        drive(1'b0, 1'b1);
        tick(2);
        chk("st_no_valid", vcnt - vsnap, 0);
        drive(1'b0, 1'b0);
        tick(4);
        drive(1'b1, 1'b0);
        tick(1);
        chk("st_then_n_on", dtm_np, 4);
        r_dtm_clr = 1'b1;
        tick(1);
        r_dtm_clr = 1'b0;
        chk("st_clr_st", st_flag, 0);
        chk("st_clr_short", dt_short_flag, 0);

        // 4: saturating gap, then P release and re-assert
        drive(1'b0, 1'b0);
        tick(1500);
        drive(1'b0, 1'b1);
        tick(1);
        chk("sat_pn", dtm_pn, 1023);
        chk("sat_short", dt_short_flag, 0);
        tick(3);
        drive(1'b0, 1'b0);
        tick(9);
        drive(1'b1, 1'b0);
        tick(1);
        chk("sat_np", dtm_np, 9);
        tick(3);
        vsnap = vcnt;
        drive(1'b0, 1'b0);
        tick(5);
        drive(1'b1, 1'b0);
        tick(2);
        chk("reassert_no_valid", vcnt - vsnap, 0);
        chk("reassert_pn_hold", dtm_pn, 1023);

        // 5: active-low pins, direct P->N hand-off
        r_dtm_en = 1'b0;
        tick(1);
        r_ccp     = 1'b1;
        r_ccnp    = 1'b1;
        r_dtg_min = 10'd4;
        drive(1'b1, 1'b0);
        r_dtm_en = 1'b1;
        tick(2);
        drive(1'b0, 1'b1);
        chk("pol_pin_n", channeln, 0);
        tick(1);
        chk("hand_pn", dtm_pn, 0);
        chk("hand_valid", dtm_valid, 1);
        chk("hand_short", dt_short_flag, 1);

        // 6: disable mid-gap, then asynchronous reset mid-gap
        r_dtm_en = 1'b0;
        tick(1);
        r_ccp  = 1'b0;
        r_ccnp = 1'b0;
        drive(1'b1, 1'b0);
        r_dtm_en = 1'b1;
        tick(3);
        drive(1'b0, 1'b0);
        tick(6);
        drive(1'b0, 1'b1);
        tick(1);
        chk("dis_pre_pn", dtm_pn, 6);
        drive(1'b1, 1'b0);
        tick(3);
        vsnap = vcnt;
        drive(1'b0, 1'b0);
        tick(4);
        r_dtm_en = 1'b0;
        tick(1);
        drive(1'b0, 1'b1);
        tick(3);
        chk("dis_no_valid", vcnt - vsnap, 0);
        chk("dis_pn_hold", dtm_pn, 6);
        r_dtm_en = 1'b1;
        drive(1'b1, 1'b0);
        tick(3);
        drive(1'b0, 1'b0);
        tick(3);
        pe_gen_rstn = 1'b0;
        #2;
        chk("arst_pn", dtm_pn, 0);
        chk("arst_np", dtm_np, 0);
        chk("arst_valid", dtm_valid, 0);
        chk("arst_short", dt_short_flag, 0);
        chk("arst_st", st_flag, 0);
        chk("arst_brk", st_brk, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
